// File: rtl/tl_sensor_cond.sv
// -----------------------------------------------------------------------------
// tl_sensor_cond
//
// Front end of the left-turn traffic light controller. Each of the four raw
// vehicle detectors is brought into the clock domain with a two-flop
// synchronizer and then debounced. The debounced levels are combined with a
// phase-dwell timer to form the hold requests the controller consumes. The
// timer enforces a minimum phase length, and it caps the phase length under
// continuous traffic.
//
// The controller's light outputs La/Lb are fed back here so that the block
// knows which phase is currently being served. They are pure state decodes
// in the controller, so feeding them combinationally into Ta..Tbl does not
// form a loop.
//
// Parameters
//   DEB_CYC  synced cycles a detector must hold a new level before the
//            filtered level follows it (>= 1)
//   MIN_CYC  minimum served-phase length in cycles (>= 1)
//   MAX_CYC  maximum served-phase length under continuous traffic
//            (>= MIN_CYC)
//
// Ports
//   clk      rising-edge clock
//   reset_n  synchronous, active-low reset
//   det_a    raw asynchronous detector, street A through
//   det_al   raw asynchronous detector, street A left-turn
//   det_b    raw asynchronous detector, street B through
//   det_bl   raw asynchronous detector, street B left-turn
//   La, Lb   controller light state (GREEN=00 YELLOW=01 LEFT=10 RED=11)
//   Ta       hold request for the A-green phase
//   Tal      hold request for the A-left phase
//   Tb       hold request for the B-green phase
//   Tbl      hold request for the B-left phase
// -----------------------------------------------------------------------------
module tl_sensor_cond #(
  parameter int DEB_CYC = 4,
  parameter int MIN_CYC = 8,
  parameter int MAX_CYC = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       det_a,
  input  logic       det_al,
  input  logic       det_b,
  input  logic       det_bl,
  input  logic [1:0] La,
  input  logic [1:0] Lb,
  output logic       Ta,
  output logic       Tal,
  output logic       Tb,
  output logic       Tbl
);

  typedef enum logic [1:0] {
    GREEN  = 2'b00,
    YELLOW = 2'b01,
    LEFT   = 2'b10,
    RED    = 2'b11
  } light_e;

  // Lane index order used by every per-lane vector below.
  localparam int LANE_A  = 0;
  localparam int LANE_AL = 1;
  localparam int LANE_B  = 2;
  localparam int LANE_BL = 3;

  localparam int DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int TW    = $clog2(MAX_CYC + 1);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
  localparam logic [TW-1:0]    MIN_LIM  = TW'(MIN_CYC - 1);
  localparam logic [TW-1:0]    MAX_LIM  = TW'(MAX_CYC - 1);

  logic [3:0]       det;
  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       filt;
  logic [DEB_W-1:0] deb_cnt [4];

  logic [3:0]       phase_q;
  logic [TW-1:0]    timer;
  logic             chg;
  logic [TW-1:0]    elapsed;
  logic [3:0]       hold;

  assign det = {det_bl, det_b, det_al, det_a};

  // A change of the {La,Lb} code marks the first cycle of a new phase.
  // Resetting phase_q to 4'b1111 makes the first cycle after reset a phase
  // entry whenever the controller starts in S0.
  assign chg     = ({La, Lb} != phase_q);
  assign elapsed = chg ? '0 : timer;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of its neighbours, as the hardware
  // does.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1   <= '0;
      sync2   <= '0;
      filt    <= '0;
      // NOTE: the debounce counters are a handful of flops. They are
      // cleared explicitly so that a mid-operation reset discards any
      // partial debounce history.
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
      phase_q <= 4'b1111;
      timer   <= '0;
    end else begin
      sync1 <= det;
      sync2 <= sync1;

      // A new level must persist for DEB_CYC synced cycles. Any return to
      // the filtered level restarts the count.
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == filt[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          filt[i]    <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end

      phase_q <= {La, Lb};

      // The timer saturates at MAX_CYC-1, which is enough to decide every
      // hold comparison, so it never wraps back into the minimum window.
      if (chg) begin
        timer <= TW'(1);
      end else if (timer >= MAX_LIM) begin
        timer <= MAX_LIM;
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end

  // NOTE: every signal written here receives a default value first, so
  // no latch can be inferred for any path.
  always_comb begin
    hold = '0;
    for (int i = 0; i < 4; i++) begin
      hold[i] = (elapsed < MIN_LIM) || (filt[i] && (elapsed < MAX_LIM));
    end
  end

  // The lane being served reports its hold request. Every other lane
  // reports its filtered demand, so the controller can tell whether it has
  // a reason to move there.
  assign Ta  = (light_e'(La) == GREEN) ? hold[LANE_A]  : filt[LANE_A];
  assign Tal = (light_e'(La) == LEFT)  ? hold[LANE_AL] : filt[LANE_AL];
  assign Tb  = (light_e'(Lb) == GREEN) ? hold[LANE_B]  : filt[LANE_B];
  assign Tbl = (light_e'(Lb) == LEFT)  ? hold[LANE_BL] : filt[LANE_BL];

endmodule

// File: tb/tb_tl_sensor_cond.sv
// -----------------------------------------------------------------------------
// tb_tl_sensor_cond
//
// Directed bench for tl_sensor_cond with the default parameters
// (DEB_CYC=4, MIN_CYC=8, MAX_CYC=32).
//
// Inputs are driven 1 time unit after a rising edge. Outputs are sampled
// 2 units after that edge, well before the falling edge. "k" counts the
// cycles since a phase entry. The cycle in which the new {La,Lb} code
// is first presented is k=0.
// -----------------------------------------------------------------------------
module tb_tl_sensor_cond;

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] LEFT   = 2'b10;
  localparam logic [1:0] RED    = 2'b11;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       det_a, det_al, det_b, det_bl;
  logic [1:0] La, Lb;
  logic       Ta, Tal, Tb, Tbl;

  int errors = 0;
  int checks = 0;

  tl_sensor_cond #(
    .DEB_CYC(4),
    .MIN_CYC(8),
    .MAX_CYC(32)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .det_a  (det_a),
    .det_al (det_al),
    .det_b  (det_b),
    .det_bl (det_bl),
    .La     (La),
    .Lb     (Lb),
    .Ta     (Ta),
    .Tal    (Tal),
    .Tb     (Tb),
    .Tbl    (Tbl)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge, where inputs may change.
  task automatic edge_drive();
    @(posedge clk);
    #1;
  endtask

  // Advance to the sampling point after the next rising edge.
  task automatic edge_sample();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_edges(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
  endtask

  // 1. Reset with the controller in S0. Ta is held through k=0..6 and
  //    released at k=7. The other requests stay low.
  task automatic test_reset();
    reset_n = 1'b0;
    det_a = 1'b0; det_al = 1'b0; det_b = 1'b0; det_bl = 1'b0;
    La = GREEN; Lb = RED;
    edge_drive();
    edge_drive();
    reset_n = 1'b1;
    #1;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) edge_sample();
      checks++;
      if (Ta !== (k < 7)) begin
        errors++;
        $display("FAIL reset_ta k=%0d got=%b expected=%b", k, Ta, (k < 7));
      end
      checks++;
      if ({Tal, Tb, Tbl} !== 3'b000) begin
        errors++;
        $display("FAIL reset_others k=%0d got=%b expected=000", k, {Tal, Tb, Tbl});
      end
    end
  endtask

  // 2. Debounce. A 3-cycle pulse is filtered out. A held level appears
  //    6 edges after the raw change, on det_b and det_bl simultaneously.
  task automatic test_debounce();
    edge_drive();
    det_b = 1'b1;
    wait_edges(3);
    #1;
    det_b = 1'b0;
    for (int k = 0; k < 10; k++) begin
      edge_sample();
      checks++;
      if (Tb !== 1'b0) begin
        errors++;
        $display("FAIL deb_glitch k=%0d got=%b expected=0", k, Tb);
      end
    end
    edge_drive();
    det_b  = 1'b1;
    det_bl = 1'b1;
    #1;
    for (int e = 0; e <= 8; e++) begin
      if (e > 0) edge_sample();
      checks++;
      if (Tb !== (e >= 6)) begin
        errors++;
        $display("FAIL deb_rise_b edge=%0d got=%b expected=%b", e, Tb, (e >= 6));
      end
      checks++;
      if (Tbl !== (e >= 6)) begin
        errors++;
        $display("FAIL deb_rise_bl edge=%0d got=%b expected=%b", e, Tbl, (e >= 6));
      end
    end
    edge_drive();
    det_b  = 1'b0;
    det_bl = 1'b0;
    wait_edges(8);
    #2;
    checks++;
    if ({Tb, Tbl} !== 2'b00) begin
      errors++;
      $display("FAIL deb_fall got=%b expected=00", {Tb, Tbl});
    end
  endtask

  // 3. No traffic. A-green lasts exactly MIN_CYC=8 cycles.
  task automatic test_no_traffic();
    int len;
    edge_drive();
    La = RED; Lb = GREEN;
    wait_edges(3);
    #1;
    La = GREEN; Lb = RED;
    #1;
    len = -1;
    for (int k = 0; k < 40 && len < 0; k++) begin
      if (k > 0) edge_sample();
      if (k <= 7) begin
        checks++;
        if (Ta !== (k < 7)) begin
          errors++;
          $display("FAIL notraf_ta k=%0d got=%b expected=%b", k, Ta, (k < 7));
        end
      end
      if (Ta === 1'b0) len = k + 1;
    end
    checks++;
    if (len != 8) begin
      errors++;
      $display("FAIL notraf_len got=%0d expected=8", len);
    end
  endtask

  // 4. Continuous traffic. A-green is capped at MAX_CYC=32 cycles, and the
  //    saturated timer keeps Ta low. An unserved code (YELLOW) passes
  //    filt_a straight through.
  task automatic test_max_traffic();
    int len;
    edge_drive();
    La = YELLOW; Lb = RED;
    det_a = 1'b1;
    wait_edges(8);
    #2;
    checks++;
    if (Ta !== 1'b1) begin
      errors++;
      $display("FAIL yellow_passthru got=%b expected=1", Ta);
    end
    edge_drive();
    La = GREEN;
    #1;
    len = -1;
    for (int k = 0; k <= 80; k++) begin
      if (k > 0) edge_sample();
      checks++;
      if (Ta !== (k < 31)) begin
        errors++;
        $display("FAIL maxtraf_ta k=%0d got=%b expected=%b", k, Ta, (k < 31));
      end
      if (Ta === 1'b0 && len < 0) len = k + 1;
    end
    checks++;
    if (len != 32) begin
      errors++;
      $display("FAIL maxtraf_len got=%0d expected=32", len);
    end
    det_a = 1'b0;
  endtask

  // 5. Early release in A-left. filt_al falling at k=12 releases at once.
  //    Falling at k=3 is still held by the minimum until k=7.
  task automatic test_early_release();
    edge_drive();
    La = RED; Lb = GREEN;
    det_al = 1'b1;
    wait_edges(8);
    #2;
    checks++;
    if (Tal !== 1'b1) begin
      errors++;
      $display("FAIL left_filt_up got=%b expected=1", Tal);
    end
    edge_drive();
    La = LEFT; Lb = RED;
    #1;
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) begin
        edge_drive();
        if (k == 6) det_al = 1'b0;
        #1;
      end
      checks++;
      if (Tal !== (k < 12)) begin
        errors++;
        $display("FAIL rel12_tal k=%0d got=%b expected=%b", k, Tal, (k < 12));
      end
    end
    edge_drive();
    La = RED; Lb = GREEN;
    det_al = 1'b1;
    wait_edges(8);
    #1;
    det_al = 1'b0;
    wait_edges(3);
    #1;
    La = LEFT; Lb = RED;
    #1;
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) edge_sample();
      checks++;
      if (Tal !== (k < 7)) begin
        errors++;
        $display("FAIL rel3_tal k=%0d got=%b expected=%b", k, Tal, (k < 7));
      end
    end
  endtask

  // 6. Reset at k=20 of a B-left phase with det_bl=1. The filter clears
  //    and re-syncs 6 edges later. The controller restarts in S0 with a
  //    fresh phase at k=0.
  task automatic test_reset_mid_phase();
    edge_drive();
    La = RED; Lb = GREEN;
    det_bl = 1'b1;
    wait_edges(8);
    #1;
    Lb = LEFT;
    #1;
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) edge_sample();
      checks++;
      if (Tbl !== 1'b1) begin
        errors++;
        $display("FAIL midrst_pre_tbl k=%0d got=%b expected=1", k, Tbl);
      end
    end
    reset_n = 1'b0;
    edge_drive();
    reset_n = 1'b1;
    La = GREEN; Lb = RED;
    #1;
    for (int j = 0; j < 10; j++) begin
      if (j > 0) edge_sample();
      checks++;
      if (Tbl !== (j >= 6)) begin
        errors++;
        $display("FAIL midrst_tbl j=%0d got=%b expected=%b", j, Tbl, (j >= 6));
      end
      checks++;
      if (Ta !== (j < 7)) begin
        errors++;
        $display("FAIL midrst_ta j=%0d got=%b expected=%b", j, Ta, (j < 7));
      end
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_no_traffic();
    test_max_traffic();
    test_early_release();
    test_reset_mid_phase();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
